// File: rtl/i2c_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_cmd_responder: I2C slave that applies write command bytes to an      |
// | 8-bit counter; optional read-back enabled by I2C_CMD_RESPONDER_READ_EN.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_cmd_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter logic [7:0] COUNT_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] count,
  output logic       cmd_valid,
  output logic [7:0] cmd_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    CMD      = 3'd3,
    CMD_ACK  = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

`ifdef I2C_CMD_RESPONDER_READ_EN
  localparam logic READ_OK = 1'b1;
  logic rw;
`else
  localparam logic READ_OK = 1'b0;
`endif

  state_t     state;
  logic       scl_meta, scl_sync, scl_prev;
  logic       sda_meta, sda_sync, sda_prev;
  logic [3:0] bit_cnt;
  logic [7:0] shift;
  logic       ack_phase;
  logic       sda_low;

  logic       scl_rise, scl_fall, bus_start, bus_stop;
  logic [7:0] byte_in;

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign bus_start = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign bus_stop  = scl_sync & scl_prev & ~sda_prev & sda_sync;
  assign byte_in   = {shift[6:0], sda_sync};

  assign i2c_sda = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta  <= 1'b1;
      scl_sync  <= 1'b1;
      scl_prev  <= 1'b1;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      sda_prev  <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      ack_phase <= 1'b0;
      sda_low   <= 1'b0;
      count     <= COUNT_INIT;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'h00;
`ifdef I2C_CMD_RESPONDER_READ_EN
      rw        <= 1'b0;
`endif
    end else begin
      scl_meta  <= i2c_scl;
      scl_sync  <= scl_meta;
      scl_prev  <= scl_sync;
      sda_meta  <= i2c_sda;
      sda_sync  <= sda_meta;
      sda_prev  <= sda_sync;
      cmd_valid <= 1'b0;

      if (bus_start) begin
        state     <= ADDR;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_low   <= 1'b0;
      end else if (bus_stop) begin
        state     <= IDLE;
        ack_phase <= 1'b0;
        sda_low   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR: if (scl_rise) begin
            shift <= byte_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
`ifdef I2C_CMD_RESPONDER_READ_EN
              rw      <= sda_sync;
`endif
              if ((byte_in[7:1] == SLAVE_ADDR) && (!sda_sync || READ_OK))
                state <= ADDR_ACK;
              else
                state <= IGNORE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

          // First SCL fall after the byte pulls SDA low, the next one releases it.
          ADDR_ACK, CMD_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              sda_low   <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= 4'd0;
`ifdef I2C_CMD_RESPONDER_READ_EN
              if ((state == ADDR_ACK) && rw) begin
                state   <= RD_DATA;
                sda_low <= ~count[7];
                shift   <= {count[6:0], 1'b0};
              end else
`endif
              begin
                sda_low <= 1'b0;
                state   <= CMD;
              end
            end
          end

          CMD: if (scl_rise) begin
            shift <= byte_in;
            if (bit_cnt == 4'd7) begin
              bit_cnt   <= 4'd0;
              state     <= CMD_ACK;
              cmd_valid <= 1'b1;
              cmd_code  <= byte_in;
              case (byte_in)
                8'h01:   count <= count + 8'd1;
                8'h02:   count <= count - 8'd1;
                8'h03:   count <= COUNT_INIT;
                default: ;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end

`ifdef I2C_CMD_RESPONDER_READ_EN
          // The MSB is already on the bus; each later bit follows an SCL fall.
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_low   <= 1'b0;
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                state     <= RD_ACK;
              end else begin
                sda_low <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda_sync) state <= IGNORE;
              else          ack_phase <= 1'b1;
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              state     <= RD_DATA;
              sda_low   <= ~count[7];
              shift     <= {count[6:0], 1'b0};
            end
          end
`endif

          IGNORE: ;

          default: begin
            state   <= IDLE;
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_cmd_responder: bit-banged I2C master driving i2c_cmd_responder.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_cmd_responder;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda_bus;
  logic [7:0] count;
  logic [7:0] cmd_code;
  logic       cmd_valid;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_cmd_responder dut (
    .clk       (clk),
    .reset     (reset),
    .i2c_scl   (m_scl),
    .i2c_sda   (sda_bus),
    .count     (count),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int slave_lows = 0;
  int last_valid_cyc = 0;
  int bit_rise_cyc = 0;
  int bit0_cyc = 0;
  logic slave_low_prev = 1'b0;

  wire slave_low = (sda_bus === 1'b0) && !m_sda_low;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid === 1'b1) begin
      valid_cycles   <= valid_cycles + 1;
      last_valid_cyc <= cyc;
    end
    if (slave_low && !slave_low_prev) slave_lows <= slave_lows + 1;
    slave_low_prev <= slave_low;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; qwait();
    m_scl = 1'b1;     qwait();
    m_sda_low = 1'b1; qwait();
    m_scl = 1'b0;     qwait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; qwait();
    m_scl = 1'b1;     qwait();
    m_sda_low = 1'b0; qwait();
  endtask

  task automatic put_bit(input logic b, output logic s);
    m_sda_low = !b; qwait();
    m_scl = 1'b1;
    bit_rise_cyc = cyc;
    qwait();
    s = sda_bus;
    qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) put_bit(b[i], s);
    bit0_cyc = bit_rise_cyc;
    put_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      put_bit(1'b1, s);
      d[i] = s;
    end
    put_bit(nack, s);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (count !== 8'h00)    begin n_fail++; $display("FAIL reset_count got=%h exp=00", count); end
    n_cmp++; if (cmd_code !== 8'h00) begin n_fail++; $display("FAIL reset_cmd_code got=%h exp=00", cmd_code); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    n_cmp++; if (sda_bus !== 1'b1)   begin n_fail++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
    reset = 1'b0;
    qwait();
  endtask

  task automatic test_single_inc();
    int v0, l0, lat;
    logic a1, a2;
    v0 = valid_cycles; l0 = slave_lows;
    i2c_start(); write_byte(8'h84, a1); write_byte(8'h01, a2); i2c_stop(); qwait();
    lat = last_valid_cyc - bit0_cyc;
    n_cmp++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL inc_addr_ack got=%b exp=0", a1); end
    n_cmp++; if (a2 !== 1'b0) begin n_fail++; $display("FAIL inc_cmd_ack got=%b exp=0", a2); end
    n_cmp++; if (slave_lows - l0 != 2) begin n_fail++; $display("FAIL inc_ack_lows got=%0d exp=2", slave_lows - l0); end
    n_cmp++; if (count !== 8'h01) begin n_fail++; $display("FAIL inc_count got=%h exp=01", count); end
    n_cmp++; if (valid_cycles - v0 != 1) begin n_fail++; $display("FAIL inc_valid_cycles got=%0d exp=1", valid_cycles - v0); end
    n_cmp++; if (cmd_code !== 8'h01) begin n_fail++; $display("FAIL inc_cmd_code got=%h exp=01", cmd_code); end
    n_cmp++; if (lat < 3 || lat > 5) begin n_fail++; $display("FAIL inc_latency got=%0d exp=3..5 clk", lat); end
  endtask

  task automatic test_wrap();
    logic a1, a2;
    i2c_start(); write_byte(8'h84, a1); write_byte(8'h03, a2); i2c_stop(); qwait();
    n_cmp++; if (count !== 8'h00) begin n_fail++; $display("FAIL wrap_clear got=%h exp=00", count); end
    i2c_start(); write_byte(8'h84, a1); write_byte(8'h02, a2); i2c_stop(); qwait();
    n_cmp++; if (count !== 8'hFF) begin n_fail++; $display("FAIL wrap_dec got=%h exp=FF", count); end
    n_cmp++; if (cmd_code !== 8'h02) begin n_fail++; $display("FAIL wrap_dec_code got=%h exp=02", cmd_code); end
    i2c_start(); write_byte(8'h84, a1); write_byte(8'h01, a2); i2c_stop(); qwait();
    n_cmp++; if (count !== 8'h00) begin n_fail++; $display("FAIL wrap_inc got=%h exp=00", count); end
  endtask

  task automatic test_wrong_addr();
    int v0, l0;
    logic a1, a2;
    v0 = valid_cycles; l0 = slave_lows;
    i2c_start(); write_byte(8'h86, a1); write_byte(8'h01, a2); i2c_stop(); qwait();
    n_cmp++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_nack got=%b exp=1", a1); end
    n_cmp++; if (slave_lows - l0 != 0) begin n_fail++; $display("FAIL wrong_addr_lows got=%0d exp=0", slave_lows - l0); end
    n_cmp++; if (count !== 8'h00) begin n_fail++; $display("FAIL wrong_addr_count got=%h exp=00", count); end
    n_cmp++; if (valid_cycles - v0 != 0) begin n_fail++; $display("FAIL wrong_addr_valid got=%0d exp=0", valid_cycles - v0); end
  endtask

  task automatic test_back_to_back();
    int v0, l0;
    logic a0, a1, a2, a3, a4;
    v0 = valid_cycles; l0 = slave_lows;
    i2c_start(); write_byte(8'h84, a0); write_byte(8'h01, a1); write_byte(8'h01, a2);
    n_cmp++; if (count !== 8'h02) begin n_fail++; $display("FAIL b2b_mid_count got=%h exp=02", count); end
    write_byte(8'h03, a3); write_byte(8'h01, a4); i2c_stop(); qwait();
    n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin n_fail++; $display("FAIL b2b_acks got=%b exp=00000", {a0, a1, a2, a3, a4}); end
    n_cmp++; if (valid_cycles - v0 != 4) begin n_fail++; $display("FAIL b2b_valid got=%0d exp=4", valid_cycles - v0); end
    n_cmp++; if (slave_lows - l0 != 5) begin n_fail++; $display("FAIL b2b_ack_lows got=%0d exp=5", slave_lows - l0); end
    n_cmp++; if (count !== 8'h01) begin n_fail++; $display("FAIL b2b_count got=%h exp=01", count); end
    n_cmp++; if (cmd_code !== 8'h01) begin n_fail++; $display("FAIL b2b_cmd_code got=%h exp=01", cmd_code); end
  endtask

  task automatic test_partial_and_reset();
    int v0, l0, w;
    logic a, s;
    logic [7:0] addr_w;
    v0 = valid_cycles;
    i2c_start(); write_byte(8'h84, a);
    for (int i = 0; i < 4; i++) put_bit(1'b0, s);
    i2c_stop(); qwait();
    n_cmp++; if (count !== 8'h01) begin n_fail++; $display("FAIL partial_count got=%h exp=01", count); end
    n_cmp++; if (valid_cycles - v0 != 0) begin n_fail++; $display("FAIL partial_valid got=%0d exp=0", valid_cycles - v0); end

    addr_w = 8'h84;
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(addr_w[i], s);
    m_sda_low = 1'b0;
    w = 0;
    while (!slave_low && w < 20) begin @(posedge clk); w++; end
    n_cmp++; if (slave_low !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ack_seen got=%b exp=1", slave_low); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sda got=%b exp=1", sda_bus); end
    n_cmp++; if (count !== 8'h00) begin n_fail++; $display("FAIL rst_mid_count got=%h exp=00", count); end
    @(negedge clk); reset = 1'b0;

    v0 = valid_cycles; l0 = slave_lows;
    put_bit(1'b1, s);
    write_byte(8'h01, a);
    i2c_stop(); qwait();
    n_cmp++; if (slave_lows - l0 != 0) begin n_fail++; $display("FAIL rst_ignore_lows got=%0d exp=0", slave_lows - l0); end
    n_cmp++; if (valid_cycles - v0 != 0) begin n_fail++; $display("FAIL rst_ignore_valid got=%0d exp=0", valid_cycles - v0); end
    n_cmp++; if (count !== 8'h00) begin n_fail++; $display("FAIL rst_ignore_count got=%h exp=00", count); end
    i2c_start(); write_byte(8'h84, a); write_byte(8'h01, s); i2c_stop(); qwait();
    n_cmp++; if (count !== 8'h01) begin n_fail++; $display("FAIL rst_recover_count got=%h exp=01", count); end
  endtask

  task automatic test_read();
    int l0;
    logic a, s;
    logic [7:0] d;
`ifdef I2C_CMD_RESPONDER_READ_EN
    i2c_start(); write_byte(8'h84, a); write_byte(8'h03, s);
    for (int i = 0; i < 90; i++) write_byte(8'h01, s);
    i2c_stop(); qwait();
    n_cmp++; if (count !== 8'h5A) begin n_fail++; $display("FAIL read_setup_count got=%h exp=5A", count); end
    i2c_start(); write_byte(8'h85, a);
    n_cmp++; if (a !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack got=%b exp=0", a); end
    read_byte(d, 1'b1);
    n_cmp++; if (d !== 8'h5A) begin n_fail++; $display("FAIL read_data got=%h exp=5A", d); end
    l0 = slave_lows;
    read_byte(d, 1'b1);
    n_cmp++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_ignore_data got=%h exp=FF", d); end
    n_cmp++; if (slave_lows - l0 != 0) begin n_fail++; $display("FAIL read_ignore_lows got=%0d exp=0", slave_lows - l0); end
    i2c_stop(); qwait();
    n_cmp++; if (count !== 8'h5A) begin n_fail++; $display("FAIL read_count_kept got=%h exp=5A", count); end
`else
    l0 = slave_lows;
    i2c_start(); write_byte(8'h85, a);
    n_cmp++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_nack got=%b exp=1", a); end
    read_byte(d, 1'b1);
    i2c_stop(); qwait();
    n_cmp++; if (d !== 8'hFF) begin n_fail++; $display("FAIL read_ignore_data got=%h exp=FF", d); end
    n_cmp++; if (slave_lows - l0 != 0) begin n_fail++; $display("FAIL read_lows got=%0d exp=0", slave_lows - l0); end
    n_cmp++; if (count !== 8'h01) begin n_fail++; $display("FAIL read_count_kept got=%h exp=01", count); end
    s = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1;
    repeat (4) @(posedge clk);
    test_reset();
    test_single_inc();
    test_wrap();
    test_wrong_addr();
    test_back_to_back();
    test_partial_and_reset();
    test_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
